// File: rtl/bidir_pad_ctrl.sv
// bidir_pad_ctrl
// Direction and turnaround controller for one bidirectional device pad.
// Owns the pad output enable, registers outbound data onto the pad and
// synchronizes inbound data off it. A non-driven gap of TURNAROUND cycles
// separates every change of pad ownership.
//
// Optional feature: define BIDIR_PAD_EDGE_DET_EN to add the rx_edge output,
// a one-cycle pulse whenever the synchronized pad value changes while the
// inbound sample is valid. Without the macro the port and its logic are absent.

module bidir_pad_ctrl #(
   parameter int TURNAROUND  = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic dir_req,
   input  logic tx_valid,
   input  logic tx_data,
   output logic tx_ready,
   output logic pad_o,
   output logic pad_oe,
   input  logic pad_i,
   output logic rx_data,
   output logic rx_valid,
   output logic mode
`ifdef BIDIR_PAD_EDGE_DET_EN
   ,
   output logic rx_edge
`endif
);

   // Counter reload values; TURNAROUND fits 1..15 and SYNC_STAGES fits 2..4.
   localparam logic [3:0] TA_LOAD    = 4'(TURNAROUND - 1);
   localparam logic [1:0] FLUSH_LOAD = 2'(SYNC_STAGES - 1);

   typedef enum logic [1:0] {
      ST_IN     = 2'd0,
      ST_TA_OUT = 2'd1,
      ST_OUT    = 2'd2,
      ST_TA_IN  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [3:0] ta_cnt;
   logic [1:0] flush_cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic accept;
   logic enter_in;
   logic enter_ta;

   // A transfer only happens when the fabric offers a bit and the block is
   // willing to take it; tx_ready already folds in the state and dir_req.
   assign accept = tx_valid & tx_ready;

   // Entering IN from either turnaround state restarts the synchronizer flush.
   assign enter_in = (state != ST_IN) && (state_next == ST_IN);

   // Entering either turnaround state reloads the gap counter.
   assign enter_ta = ((state != ST_TA_OUT) && (state_next == ST_TA_OUT)) ||
                     ((state != ST_TA_IN)  && (state_next == ST_TA_IN));

   // State register; reset returns straight to IN with no turnaround so the
   // pad is released asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: a request abort in TA_OUT wins over the counter so the
   // pad is never driven, while TA_IN always runs to completion.
   always_comb begin
      state_next = state;
      case (state)
         ST_IN: begin
            if (dir_req) begin
               state_next = ST_TA_OUT;
            end
         end
         ST_TA_OUT: begin
            if (!dir_req) begin
               state_next = ST_IN;
            end else if (ta_cnt == 4'd0) begin
               state_next = ST_OUT;
            end
         end
         ST_OUT: begin
            if (!dir_req) begin
               state_next = ST_TA_IN;
            end
         end
         ST_TA_IN: begin
            if (ta_cnt == 4'd0) begin
               state_next = ST_IN;
            end
         end
         default: begin
            state_next = ST_IN;
         end
      endcase
   end

   // Output decode straight from the state register so pad_oe and mode are
   // glitch-free; tx_ready drops combinationally as soon as a release is asked.
   always_comb begin
      pad_oe   = 1'b0;
      mode     = 1'b0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      case (state)
         ST_OUT: begin
            pad_oe   = 1'b1;
            mode     = 1'b1;
            tx_ready = dir_req;
         end
         ST_IN: begin
            rx_valid = (flush_cnt == 2'd0);
         end
         default: begin
            pad_oe   = 1'b0;
         end
      endcase
   end

   // Turnaround counter: loaded on entry to a turnaround state, counts down
   // while in one and is ignored elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ta_cnt <= 4'd0;
      end else if (enter_ta) begin
         ta_cnt <= TA_LOAD;
      end else if (((state == ST_TA_OUT) || (state == ST_TA_IN)) && (ta_cnt != 4'd0)) begin
         ta_cnt <= ta_cnt - 4'd1;
      end
   end

   // Flush counter: after reset or on re-entering IN, wait until stale
   // samples taken while the pad was driven have left the synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= FLUSH_LOAD;
      end else if (enter_in) begin
         flush_cnt <= FLUSH_LOAD;
      end else if ((state == ST_IN) && (flush_cnt != 2'd0)) begin
         flush_cnt <= flush_cnt - 2'd1;
      end
   end

   // Outbound data register: takes the offered bit on an accept and otherwise
   // holds, including across direction changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_o <= 1'b0;
      end else if (accept) begin
         pad_o <= tx_data;
      end
   end

   // Inbound synchronizer: free-running shift chain in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      end
   end

   assign rx_data = sync_q[SYNC_STAGES-1];

`ifdef BIDIR_PAD_EDGE_DET_EN
   logic rx_prev;
   logic valid_prev;

   // Remember last cycle's sample and validity so a change is only flagged
   // when both the old and the new value are trustworthy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_prev    <= 1'b0;
         valid_prev <= 1'b0;
      end else begin
         rx_prev    <= rx_data;
         valid_prev <= rx_valid;
      end
   end

   assign rx_edge = rx_valid & valid_prev & (rx_data ^ rx_prev);
`endif

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// tb_bidir_pad_ctrl
// Directed bench for bidir_pad_ctrl with TURNAROUND=2 and SYNC_STAGES=2.
// Outbound transfers are predicted into a queue when driven and popped when
// pad_o is expected to show them. Define BIDIR_PAD_EDGE_DET_EN to also
// exercise rx_edge.

module tb_bidir_pad_ctrl;

   logic clk;
   logic rst_n;
   logic dir_req;
   logic tx_valid;
   logic tx_data;
   logic tx_ready;
   logic pad_o;
   logic pad_oe;
   logic pad_i;
   logic rx_data;
   logic rx_valid;
   logic mode;
`ifdef BIDIR_PAD_EDGE_DET_EN
   logic rx_edge;
`endif

   int checks;
   int errors;
   logic exp_q[$];
   logic exp_pad_o;
   logic popped;
   logic tx_pattern [3];

   bidir_pad_ctrl #(
      .TURNAROUND  (2),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .dir_req  (dir_req),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .pad_o    (pad_o),
      .pad_oe   (pad_oe),
      .pad_i    (pad_i),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .mode     (mode)
`ifdef BIDIR_PAD_EDGE_DET_EN
      ,
      .rx_edge  (rx_edge)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic d, input logic v, input logic td, input logic pi);
      dir_req  = d;
      tx_valid = v;
      tx_data  = td;
      pad_i    = pi;
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      exp_pad_o = 1'b0;
      tx_pattern[0] = 1'b1;
      tx_pattern[1] = 1'b0;
      tx_pattern[2] = 1'b1;
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Reset values while reset is held.
      #12;
      checkOutput("rst_pad_oe",   pad_oe,   1'b0);
      checkOutput("rst_pad_o",    pad_o,    1'b0);
      checkOutput("rst_tx_ready", tx_ready, 1'b0);
      checkOutput("rst_rx_data",  rx_data,  1'b0);
      checkOutput("rst_rx_valid", rx_valid, 1'b0);
      checkOutput("rst_mode",     mode,     1'b0);
      rst_n = 1'b1;

      // Inbound flush with pad_i held high.
      tick();
      checkOutput("flush_rx_data_e1", rx_data, 1'b0);
      checkOutput("flush_pad_oe_e1",  pad_oe,  1'b0);
      tick();
      checkOutput("flush_rx_valid_e2", rx_valid, 1'b1);
      checkOutput("flush_rx_data_e2",  rx_data,  1'b1);
      checkOutput("flush_pad_oe_e2",   pad_oe,   1'b0);

      // Output request: two undriven cycles, then drive.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("ta_out_pad_oe_e0", pad_oe,   1'b0);
      checkOutput("ta_out_mode_e0",   mode,     1'b0);
      tick();
      checkOutput("ta_out_pad_oe_e1", pad_oe,   1'b0);
      checkOutput("ta_out_rx_valid",  rx_valid, 1'b0);
      tick();
      checkOutput("out_pad_oe",   pad_oe,   1'b1);
      checkOutput("out_mode",     mode,     1'b1);
      checkOutput("out_tx_ready", tx_ready, 1'b1);

      // Outbound transfers 1,0,1 through the scoreboard.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, tx_pattern[i], 1'b1);
         checkOutput("tx_ready_accept", tx_ready, 1'b1);
         exp_q.push_back(tx_pattern[i]);
         tick();
         popped    = exp_q.pop_front();
         exp_pad_o = popped;
         checkOutput("tx_pad_o", pad_o, exp_pad_o);
      end

      // No offer: pad_o holds.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("hold_pad_o", pad_o, exp_pad_o);

      // Release while a transfer is offered: nothing is accepted.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      checkOutput("release_tx_ready", tx_ready, 1'b0);
      tick();
      checkOutput("release_pad_oe",  pad_oe, 1'b0);
      checkOutput("release_mode",    mode,   1'b0);
      checkOutput("release_pad_o",   pad_o,  exp_pad_o);
      tick();
      checkOutput("ta_in_rx_valid_e1", rx_valid, 1'b0);
      checkOutput("ta_in_tx_ready",    tx_ready, 1'b0);
      tick();
      checkOutput("in_flush_rx_valid", rx_valid, 1'b0);
      checkOutput("in_pad_oe",         pad_oe,   1'b0);
      tick();
      checkOutput("in_rx_valid",       rx_valid, 1'b1);
      checkOutput("in_pad_o_held",     pad_o,    exp_pad_o);

      // Aborted output request during TA_OUT.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("abort_pad_oe_e0", pad_oe, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("abort_pad_oe_e1",  pad_oe,   1'b0);
      checkOutput("abort_rx_valid_e1", rx_valid, 1'b0);
      tick();
      checkOutput("abort_pad_oe_e2",  pad_oe,   1'b0);
      checkOutput("abort_rx_valid_e2", rx_valid, 1'b1);
      tick();
      checkOutput("abort_pad_oe_e3",  pad_oe,   1'b0);

      // Input latency, and edge pulses when enabled.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("rx_lat_e1", rx_data, 1'b1);
      tick();
      checkOutput("rx_lat_e2", rx_data, 1'b0);
`ifdef BIDIR_PAD_EDGE_DET_EN
      checkOutput("rx_edge_fall", rx_edge, 1'b1);
`endif
      tick();
`ifdef BIDIR_PAD_EDGE_DET_EN
      checkOutput("rx_edge_fall_end", rx_edge, 1'b0);
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("rx_lat_rise_e1", rx_data, 1'b0);
      tick();
      checkOutput("rx_lat_rise_e2", rx_data, 1'b1);
`ifdef BIDIR_PAD_EDGE_DET_EN
      checkOutput("rx_edge_rise", rx_edge, 1'b1);
`endif
      tick();
`ifdef BIDIR_PAD_EDGE_DET_EN
      checkOutput("rx_edge_rise_end", rx_edge, 1'b0);
`endif

      // Reset in the middle of OUT with pad_o high.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      tick();
      checkOutput("pre_rst_pad_oe", pad_oe, 1'b1);
      checkOutput("pre_rst_pad_o",  pad_o,  1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_pad_oe",   pad_oe,   1'b0);
      checkOutput("mid_rst_pad_o",    pad_o,    1'b0);
      checkOutput("mid_rst_mode",     mode,     1'b0);
      checkOutput("mid_rst_tx_ready", tx_ready, 1'b0);
      checkOutput("mid_rst_rx_data",  rx_data,  1'b0);
      checkOutput("mid_rst_rx_valid", rx_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_pad_oe",   pad_oe,   1'b0);
      checkOutput("post_rst_rx_valid", rx_valid, 1'b1);

      checkOutput("scoreboard_empty", (exp_q.size() == 0), 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
